// File: rtl/stepper_step_scheduler.sv
// Single-axis step/dir pulse sequencer for the plotter stepper drivers.
// Setup delay, then evenly spaced pulses timed in prescaler ticks.
module stepper_step_scheduler #(
   parameter int STEP_W      = 16,
   parameter int SETUP_TICKS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic              cmd_dir,
   input  logic [5:0]        cmd_half,
   input  logic              abort,
   output logic              step,
   output logic              dir,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [STEP_W-1:0] steps_left
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_DONE
   } state_t;

   localparam logic [5:0] SETUP_LAST = 6'(SETUP_TICKS - 1);

   state_t            r_state;
   logic [5:0]        r_cnt;
   logic [5:0]        r_half;
   logic              r_step;
   logic              r_dir;
   logic              r_done;
   logic              r_aborted;
   logic [STEP_W-1:0] r_left;

   logic w_accept;
   logic w_ph_last;
   logic w_su_last;

   assign w_accept  = cmd_valid & (r_state == S_IDLE);
   assign w_ph_last = (r_cnt == r_half - 6'd1);
   assign w_su_last = (r_cnt == SETUP_LAST);

   assign cmd_ready  = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign step       = r_step;
   assign dir        = r_dir;
   assign done       = r_done;
   assign aborted    = r_aborted;
   assign steps_left = r_left;

   // Move sequencer: abort beats any phase-end tick; tick=0 freezes timing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 6'd0;
         r_half    <= 6'd1;
         r_step    <= 1'b0;
         r_dir     <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         r_left    <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dir     <= cmd_dir;
                  r_half    <= (cmd_half == 6'd0) ? 6'd1 : cmd_half;
                  r_left    <= cmd_steps;
                  r_aborted <= 1'b0;
                  r_cnt     <= 6'd0;
                  if (cmd_steps == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               if (abort) begin
                  r_step    <= 1'b0;
                  r_aborted <= 1'b1;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end else if (tick) begin
                  if (w_su_last) begin
                     r_cnt   <= 6'd0;
                     r_step  <= 1'b1;
                     r_state <= S_HIGH;
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
            end
            S_HIGH: begin
               if (abort) begin
                  r_step    <= 1'b0;
                  r_aborted <= 1'b1;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end else if (tick) begin
                  if (w_ph_last) begin
                     r_cnt   <= 6'd0;
                     r_step  <= 1'b0;
                     r_left  <= r_left - STEP_W'(1);
                     r_state <= S_LOW;
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
            end
            S_LOW: begin
               if (abort) begin
                  r_step    <= 1'b0;
                  r_aborted <= 1'b1;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end else if (tick) begin
                  if (w_ph_last) begin
                     r_cnt <= 6'd0;
                     if (r_left != '0) begin
                        r_step  <= 1'b1;
                        r_state <= S_HIGH;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stepper_step_scheduler.sv
// Directed bench for stepper_step_scheduler.
// Expected waveforms are hand-computed per cycle after accept.
module tb_stepper_step_scheduler;

   localparam int STEP_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              tick = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic              cmd_dir = 1'b0;
   logic [5:0]        cmd_half = 6'd0;
   logic              abort = 1'b0;
   logic              step;
   logic              dir;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [STEP_W-1:0] steps_left;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stepper_step_scheduler #(
      .STEP_W      (STEP_W),
      .SETUP_TICKS (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_steps  (cmd_steps),
      .cmd_dir    (cmd_dir),
      .cmd_half   (cmd_half),
      .abort      (abort),
      .step       (step),
      .dir        (dir),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .steps_left (steps_left)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int n, input logic d, input int h);
      cmd_valid = 1'b1;
      cmd_steps = STEP_W'(n);
      cmd_dir   = d;
      cmd_half  = 6'(h);
   endtask

   initial begin
      // reset with random inputs
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick      = 1'($urandom);
         cmd_valid = 1'($urandom);
         cmd_steps = STEP_W'($urandom);
         cmd_dir   = 1'($urandom);
         cmd_half  = 6'($urandom);
         abort     = 1'($urandom);
         cyc();
         chk("rst_step", 32'(step), 32'(0));
         chk("rst_busy", 32'(busy), 32'(0));
         chk("rst_done", 32'(done), 32'(0));
         chk("rst_left", 32'(steps_left), 32'(0));
      end
      chk("rst_dir", 32'(dir), 32'(0));
      chk("rst_abrt", 32'(aborted), 32'(0));
      tick = 1'b0;
      cmd_valid = 1'b0;
      abort = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_ready", 32'(cmd_ready), 32'(1));
      cyc();

      // basic move: 3 steps, half=2, tick constant
      tick = 1'b1;
      issue(3, 1'b1, 2);
      for (int j = 1; j <= 16; j++) begin
         cyc();
         cmd_valid = 1'b0;
         chk($sformatf("bas_step[%0d]", j), 32'(step),
             32'((j >= 3 && j <= 4) || (j >= 7 && j <= 8) ||
                 (j >= 11 && j <= 12)));
         chk($sformatf("bas_left[%0d]", j), 32'(steps_left),
             (j < 5) ? 32'd3 : (j < 9) ? 32'd2 : (j < 13) ? 32'd1 : 32'd0);
         chk($sformatf("bas_done[%0d]", j), 32'(done), 32'(j == 15));
         chk($sformatf("bas_busy[%0d]", j), 32'(busy), 32'(j <= 15));
         chk($sformatf("bas_dir[%0d]", j), 32'(dir), 32'(1));
      end
      chk("bas_abrt", 32'(aborted), 32'(0));

      // tick gating: tick every 4th cycle, 1 step, half=1
      tick = 1'b0;
      issue(1, 1'b1, 1);
      for (int j = 1; j <= 18; j++) begin
         cyc();
         cmd_valid = 1'b0;
         chk($sformatf("gat_step[%0d]", j), 32'(step),
             32'(j >= 9 && j <= 12));
         chk($sformatf("gat_done[%0d]", j), 32'(done), 32'(j == 17));
         chk($sformatf("gat_busy[%0d]", j), 32'(busy), 32'(j <= 17));
         tick = (j % 4 == 0);
      end

      // zero steps: done right after accept, dir still latched
      tick = 1'b1;
      issue(0, 1'b0, 5);
      cyc();
      cmd_valid = 1'b0;
      chk("zs_done1", 32'(done), 32'(1));
      chk("zs_busy1", 32'(busy), 32'(1));
      chk("zs_step1", 32'(step), 32'(0));
      chk("zs_dir", 32'(dir), 32'(0));
      chk("zs_rdy1", 32'(cmd_ready), 32'(0));
      cyc();
      chk("zs_done2", 32'(done), 32'(0));
      chk("zs_busy2", 32'(busy), 32'(0));
      chk("zs_rdy2", 32'(cmd_ready), 32'(1));

      // half=0 behaves as half=1
      issue(2, 1'b1, 0);
      for (int j = 1; j <= 8; j++) begin
         cyc();
         cmd_valid = 1'b0;
         chk($sformatf("h0_step[%0d]", j), 32'(step),
             32'(j == 3 || j == 5));
         chk($sformatf("h0_left[%0d]", j), 32'(steps_left),
             (j < 4) ? 32'd2 : (j < 6) ? 32'd1 : 32'd0);
         chk($sformatf("h0_done[%0d]", j), 32'(done), 32'(j == 7));
         chk($sformatf("h0_busy[%0d]", j), 32'(busy), 32'(j <= 7));
      end

      // abort during 2nd HIGH
      issue(10, 1'b1, 3);
      for (int j = 1; j <= 12; j++) begin
         cyc();
         cmd_valid = 1'b0;
         abort = (j == 10);
         chk($sformatf("ab_step[%0d]", j), 32'(step),
             32'((j >= 3 && j <= 5) || (j >= 9 && j <= 10)));
         chk($sformatf("ab_left[%0d]", j), 32'(steps_left),
             (j < 6) ? 32'd10 : 32'd9);
         chk($sformatf("ab_done[%0d]", j), 32'(done), 32'(j == 11));
         chk($sformatf("ab_abrt[%0d]", j), 32'(aborted), 32'(j >= 11));
         chk($sformatf("ab_busy[%0d]", j), 32'(busy), 32'(j <= 11));
      end

      // abort coincident with LOW phase-end tick wins
      issue(2, 1'b1, 1);
      for (int j = 1; j <= 6; j++) begin
         cyc();
         cmd_valid = 1'b0;
         abort = (j == 4);
         chk($sformatf("abe_step[%0d]", j), 32'(step), 32'(j == 3));
         chk($sformatf("abe_done[%0d]", j), 32'(done), 32'(j == 5));
         chk($sformatf("abe_left[%0d]", j), 32'(steps_left),
             (j < 4) ? 32'd2 : 32'd1);
         chk($sformatf("abe_busy[%0d]", j), 32'(busy), 32'(j <= 5));
      end
      chk("abe_abrt", 32'(aborted), 32'(1));

      // handshake: cmd_valid held, two back-to-back commands
      issue(1, 1'b1, 1);
      for (int j = 1; j <= 12; j++) begin
         cyc();
         if (j == 1) begin
            cmd_dir = 1'b0;
         end
         if (j == 12) begin
            cmd_valid = 1'b0;
         end
         chk($sformatf("hs_rdy[%0d]", j), 32'(cmd_ready),
             32'(j == 6 || j == 12));
         chk($sformatf("hs_dir[%0d]", j), 32'(dir), 32'(j <= 6));
         chk($sformatf("hs_done[%0d]", j), 32'(done),
             32'(j == 5 || j == 11));
         chk($sformatf("hs_busy[%0d]", j), 32'(busy),
             32'(!(j == 6 || j == 12)));
      end
      chk("hs_abrt", 32'(aborted), 32'(0));

      // async reset mid-pulse drops step without a done
      issue(5, 1'b1, 4);
      for (int j = 1; j <= 3; j++) begin
         cyc();
         cmd_valid = 1'b0;
      end
      chk("ar_step_pre", 32'(step), 32'(1));
      #3;
      rst = 1'b0;
      #1;
      chk("ar_step", 32'(step), 32'(0));
      chk("ar_busy", 32'(busy), 32'(0));
      chk("ar_left", 32'(steps_left), 32'(0));
      chk("ar_dir", 32'(dir), 32'(0));
      cyc();
      rst = 1'b1;
      cyc();
      chk("ar_done", 32'(done), 32'(0));
      chk("ar_ready", 32'(cmd_ready), 32'(1));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
